// File: rtl/array_ram_pkg.sv
// Shared definitions for the Array bus memory: default widths, bus field list, FSM encodings.
package array_ram_pkg;

    localparam int ARR_ADDR_N = 8;
    localparam int ARR_INT_N  = 8;

    // Array bus fields, in master-to-slave order: valid, we, addr, di; slave-to-master: ready, do.
    localparam int ARR_REQ_CTRL_W = 2;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

endpackage

// File: rtl/array_ram_core.sv
// Plain single-port synchronous RAM with a registered read port.
module ram_core #(
    parameter int AN = 8,
    parameter int DN = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AN-1:0] addr_i,
    input  logic [DN-1:0] di_i,
    output logic [DN-1:0] do_o
);

    logic [DN-1:0] mem [2**AN];
    logic [DN-1:0] do_q;

    // Storage has no reset so it can map onto a RAM macro; the owner zero-fills it.
    always_ff @(posedge clk_i) begin
        if (we_i) mem[addr_i] <= di_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   do_q <= '0;
        else if (re_i) do_q <= mem[addr_i];
    end

    assign do_o = do_q;

endmodule

// File: rtl/array_ram.sv
// Array bus slave RAM: zero-fills itself after reset, then serves one read or write per cycle.
module array_ram
    import array_ram_pkg::*;
#(
    parameter int AN = ARR_ADDR_N,
    parameter int DN = ARR_INT_N
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          arr_valid,
    output logic          arr_ready,
    input  logic          arr_we,
    input  logic [AN-1:0] arr_addr,
    input  logic [DN-1:0] arr_di,
    output logic [DN-1:0] arr_do
);

    logic [0:0]    state_q, state_d;
    logic [AN-1:0] clr_q, clr_d;
    logic          acc;
    logic          ram_we, ram_re;
    logic [AN-1:0] ram_addr;
    logic [DN-1:0] ram_di;

    assign arr_ready = (state_q == ST_READY);
    assign acc       = arr_valid & arr_ready;

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        if (state_q == ST_CLEAR) begin
            clr_d = clr_q + AN'(1);
            if (clr_q == '1) state_d = ST_READY;
        end
    end

    // The sweep owns the RAM port during CLEAR; bus requests are ignored then.
    always_comb begin
        ram_we   = acc & arr_we;
        ram_re   = acc & ~arr_we;
        ram_addr = arr_addr;
        ram_di   = arr_di;
        if (state_q == ST_CLEAR) begin
            ram_we   = 1'b1;
            ram_re   = 1'b0;
            ram_addr = clr_q;
            ram_di   = '0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_CLEAR;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    ram_core #(.AN(AN), .DN(DN)) u_core (
        .clk_i  (clk),
        .rst_ni (nrst),
        .we_i   (ram_we),
        .re_i   (ram_re),
        .addr_i (ram_addr),
        .di_i   (ram_di),
        .do_o   (arr_do)
    );

endmodule

// File: tb/tb_array_ram.sv
// Directed bench for array_ram: reset sweep timing, write/read ordering, idle and reset behaviour.
module tb_array_ram;

    localparam int AN = 8;
    localparam int DN = 8;

    logic          clk = 1'b0;
    logic          nrst;
    logic          arr_valid;
    logic          arr_ready;
    logic          arr_we;
    logic [AN-1:0] arr_addr;
    logic [DN-1:0] arr_di;
    logic [DN-1:0] arr_do;

    int vectors = 0;
    int miscompares = 0;

    array_ram #(.AN(AN), .DN(DN)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .arr_valid (arr_valid),
        .arr_ready (arr_ready),
        .arr_we    (arr_we),
        .arr_addr  (arr_addr),
        .arr_di    (arr_di),
        .arr_do    (arr_do)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [AN-1:0] a, input logic [DN-1:0] d);
        arr_valid = v;
        arr_we    = we;
        arr_addr  = a;
        arr_di    = d;
    endtask

    // Runs n edges of CLEAR; ready must be low except after the 256th edge of a sweep.
    task automatic sweep(input int n, input bool_last);
        for (int i = 1; i <= n; i++) begin
            tick();
            chk("clr_ready", 16'(arr_ready), 16'((bool_last != 0) && (i == n)));
            chk("clr_do", 16'(arr_do), 16'h0);
        end
    endtask

    initial begin
        nrst = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        tick();
        tick();
        chk("rst_ready", 16'(arr_ready), 16'h0);
        chk("rst_do", 16'(arr_do), 16'h0);

        nrst = 1'b1;
        sweep(256, 1);

        // three consecutive writes, then three consecutive reads
        drive(1'b1, 1'b1, 8'd1, 8'd10); tick();
        drive(1'b1, 1'b1, 8'd2, 8'd20); tick();
        drive(1'b1, 1'b1, 8'd3, 8'd30); tick();
        chk("wr_do_unchanged", 16'(arr_do), 16'h0);
        drive(1'b1, 1'b0, 8'd1, 8'd0); tick();
        chk("rd1", 16'(arr_do), 16'd10);
        drive(1'b1, 1'b0, 8'd2, 8'd0); tick();
        chk("rd2", 16'(arr_do), 16'd20);
        drive(1'b1, 1'b0, 8'd3, 8'd0); tick();
        chk("rd3", 16'(arr_do), 16'd30);
        drive(1'b1, 1'b0, 8'd200, 8'd0); tick();
        chk("rd200_unwritten", 16'(arr_do), 16'd0);

        // write then read next cycle
        drive(1'b1, 1'b1, 8'd5, 8'd77); tick();
        chk("wr5_do_hold", 16'(arr_do), 16'd0);
        drive(1'b1, 1'b0, 8'd5, 8'd0); tick();
        chk("rd5", 16'(arr_do), 16'd77);

        // idle with write fields set must not write or disturb arr_do
        drive(1'b0, 1'b1, 8'd5, 8'd99); tick(); tick(); tick();
        chk("idle_do_hold", 16'(arr_do), 16'd77);
        drive(1'b0, 1'b0, 8'd1, 8'd0); tick();
        chk("idle_rd_no_effect", 16'(arr_do), 16'd77);
        drive(1'b1, 1'b0, 8'd5, 8'd0); tick();
        chk("rd5_after_idle", 16'(arr_do), 16'd77);

        drive(1'b1, 1'b1, 8'd7, 8'd42); tick();
        drive(1'b1, 1'b0, 8'd7, 8'd0); tick();
        chk("rd7", 16'(arr_do), 16'd42);

        // reset mid-operation clears outputs at once
        drive(1'b0, 1'b0, '0, '0);
        nrst = 1'b0;
        #1;
        chk("midrst_ready", 16'(arr_ready), 16'h0);
        chk("midrst_do", 16'(arr_do), 16'h0);
        tick();
        nrst = 1'b1;

        // write attempted throughout CLEAR must be dropped
        drive(1'b1, 1'b1, 8'd0, 8'd55);
        sweep(100, 0);
        nrst = 1'b0;
        #1;
        chk("clr_rst_ready", 16'(arr_ready), 16'h0);
        tick();
        nrst = 1'b1;
        sweep(256, 1);

        drive(1'b1, 1'b0, 8'd0, 8'd0); tick();
        chk("rd0_after_clr_write", 16'(arr_do), 16'd0);
        drive(1'b1, 1'b0, 8'd7, 8'd0); tick();
        chk("rd7_after_reset", 16'(arr_do), 16'd0);
        drive(1'b1, 1'b0, 8'd1, 8'd0); tick();
        chk("rd1_after_reset", 16'(arr_do), 16'd0);
        chk("ready_final", 16'(arr_ready), 16'h1);

        drive(1'b0, 1'b0, '0, '0);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
